// File: rtl/vlc_packer.sv
// vlc_packer: turns (run, level) tokens into MPEG-2 style VLC codes
// (raw intra DC, escape-coded AC, EOB) and packs them MSB-first into 32-bit words.
module vlc_packer #(
  parameter int unsigned LEVEL_W  = 12,
  parameter int unsigned DC_W     = 12,
  parameter logic [5:0]  ESC_CODE = 6'b000001,
  parameter logic [1:0]  EOB_CODE = 2'b10
) (
  input  logic        clk,
  input  logic        reset,
  output logic        rdy,
  input  logic        en,
  input  logic [15:0] val,
  input  logic [5:0]  len,
  input  logic        blk_end,
  input  logic        dc,
  output logic [31:0] o_data,
  output logic        o_valid,
  input  logic        o_ready,
  input  logic        flush,
  output logic        flush_done,
  output logic        err,
  output logic [31:0] bit_cnt
);

  localparam int unsigned ACC_W   = 64;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned FILL_W  = 7;
  localparam int unsigned CLEN_W  = 6;
  localparam int unsigned ESC_W   = 6;
  localparam int unsigned RUN_W   = 6;
  localparam int unsigned EOB_W   = 2;
  localparam int unsigned AC_W    = ESC_W + RUN_W + LEVEL_W;
  localparam int unsigned DCE_W   = DC_W + EOB_W;
  localparam int unsigned CODE_W  = (AC_W + EOB_W > DCE_W) ? (AC_W + EOB_W) : DCE_W;

  // Saturation bounds of the AC level; the most negative code is never produced.
  localparam logic signed [15:0] LVL_MAX = 16'((1 << (LEVEL_W - 1)) - 1);
  localparam logic signed [15:0] LVL_MIN = -LVL_MAX;

  localparam logic [FILL_W-1:0] FILL_WORD = FILL_W'(WORD_W);
  localparam logic [FILL_W-1:0] FILL_ACC  = FILL_W'(ACC_W);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [31:0]         bit_cnt_q, bit_cnt_d;
  logic                err_q, err_d;
  logic                flush_done_q, flush_done_d;

  logic                word_full_c;
  logic                tok_acc_c;
  logic                word_acc_c;
  logic                illegal_c;
  logic signed [15:0]  val_s_c;
  logic signed [15:0]  clip_s_c;
  logic [LEVEL_W-1:0]  level_c;
  logic [CODE_W-1:0]   code_c;
  logic [CLEN_W-1:0]   code_len_c;
  logic [FILL_W-1:0]   shift_c;

  assign word_full_c = (fill_q >= FILL_WORD);
  assign rdy         = (state_q == ST_RUN) && !word_full_c;
  assign o_valid     = word_full_c;
  assign o_data      = acc_q[ACC_W-1 -: WORD_W];
  assign err         = err_q;
  assign flush_done  = flush_done_q;
  assign bit_cnt     = bit_cnt_q;

  assign tok_acc_c   = rdy && en;
  assign word_acc_c  = o_valid && o_ready;

  // Saturate the signed level into the symmetric escape range.
  always_comb begin
    val_s_c = $signed(val);
    if (val_s_c > LVL_MAX) begin
      clip_s_c = LVL_MAX;
    end else if (val_s_c < LVL_MIN) begin
      clip_s_c = LVL_MIN;
    end else begin
      clip_s_c = val_s_c;
    end
    level_c = clip_s_c[LEVEL_W-1:0];
  end

  // Build the right-aligned code and its length for the presented token.
  always_comb begin
    code_c     = '0;
    code_len_c = '0;
    illegal_c  = 1'b0;
    if (dc) begin
      if (blk_end) begin
        code_c     = CODE_W'({val[DC_W-1:0], EOB_CODE});
        code_len_c = CLEN_W'(DCE_W);
      end else begin
        code_c     = CODE_W'(val[DC_W-1:0]);
        code_len_c = CLEN_W'(DC_W);
      end
    end else if (val != 16'd0) begin
      if (blk_end) begin
        code_c     = CODE_W'({ESC_CODE, len, level_c, EOB_CODE});
        code_len_c = CLEN_W'(AC_W + EOB_W);
      end else begin
        code_c     = CODE_W'({ESC_CODE, len, level_c});
        code_len_c = CLEN_W'(AC_W);
      end
    end else if (blk_end) begin
      code_c     = CODE_W'(EOB_CODE);
      code_len_c = CLEN_W'(EOB_W);
    end else begin
      illegal_c  = 1'b1;
    end
    // Left shift that puts the code MSB right below the bits already held.
    shift_c = FILL_ACC - fill_q - FILL_W'(code_len_c);
  end

  // Next-state, accumulator and counter update.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    fill_d       = fill_q;
    bit_cnt_d    = bit_cnt_q;
    err_d        = 1'b0;
    flush_done_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (word_acc_c) begin
          acc_d  = acc_q << WORD_W;
          fill_d = fill_q - FILL_WORD;
        end else if (tok_acc_c) begin
          if (illegal_c) begin
            err_d = 1'b1;
          end else begin
            acc_d     = acc_q | (ACC_W'(code_c) << shift_c);
            fill_d    = fill_q + FILL_W'(code_len_c);
            bit_cnt_d = bit_cnt_q + 32'(code_len_c);
          end
        end
        // A token presented together with flush wins; flush waits for an idle cycle.
        if (flush && !en) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (word_acc_c) begin
          acc_d  = acc_q << WORD_W;
          fill_d = fill_q - FILL_WORD;
        end else if (word_full_c) begin
          fill_d = fill_q;
        end else if (fill_q != '0) begin
          // Bits below the fill point are always zero, so this is the zero pad.
          fill_d = FILL_WORD;
        end else begin
          flush_done_d = 1'b1;
          state_d      = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      acc_q        <= '0;
      fill_q       <= '0;
      bit_cnt_q    <= '0;
      err_q        <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      bit_cnt_q    <= bit_cnt_d;
      err_q        <= err_d;
      flush_done_q <= flush_done_d;
    end
  end

endmodule

// File: tb/tb_vlc_packer.sv
// Directed self-checking bench for vlc_packer.
module tb_vlc_packer;

  logic        clk;
  logic        reset;
  logic        rdy;
  logic        en;
  logic [15:0] val;
  logic [5:0]  len;
  logic        blk_end;
  logic        dc;
  logic [31:0] o_data;
  logic        o_valid;
  logic        o_ready;
  logic        flush;
  logic        flush_done;
  logic        err;
  logic [31:0] bit_cnt;

  int checks;
  int failures;
  logic [31:0] words[$];
  bit done_seen;

  vlc_packer dut (
    .clk        (clk),
    .reset      (reset),
    .rdy        (rdy),
    .en         (en),
    .val        (val),
    .len        (len),
    .blk_end    (blk_end),
    .dc         (dc),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .flush      (flush),
    .flush_done (flush_done),
    .err        (err),
    .bit_cnt    (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset with all inputs idle; returns 1 time unit after a rising edge.
  task automatic do_reset();
    reset   = 1'b1;
    en      = 1'b0;
    val     = '0;
    len     = '0;
    blk_end = 1'b0;
    dc      = 1'b0;
    o_ready = 1'b1;
    flush   = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Present one token and hold it until accepted (bounded wait).
  task automatic send_token(input logic d, input logic be, input logic [5:0] ln,
                            input logic [15:0] v);
    bit ok;
    ok      = 1'b0;
    dc      = d;
    blk_end = be;
    len     = ln;
    val     = v;
    en      = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL token_accept: rdy stayed %0b, required 1", rdy);
    end
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  // Hold flush until flush_done, collecting every word that transfers.
  task automatic run_flush();
    words.delete();
    done_seen = 1'b0;
    o_ready   = 1'b1;
    flush     = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (o_valid && o_ready) words.push_back(o_data);
      if (flush_done) begin
        done_seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    flush = 1'b0;
    checks++;
    if (!done_seen) begin
      failures++;
      $display("FAIL flush_timeout: flush_done=%0b, required 1", flush_done);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rdy, o_valid, flush_done, err} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_flags: rdy,o_valid,flush_done,err=%b required 1000",
               {rdy, o_valid, flush_done, err});
    end
    checks++;
    if (bit_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_bit_cnt: got %0d required 0", bit_cnt);
    end
  endtask

  task automatic test_dc_eob();
    do_reset();
    send_token(1'b1, 1'b0, 6'd9, 16'h0045);
    send_token(1'b0, 1'b1, 6'd7, 16'h0000);
    run_flush();
    checks++;
    if (words.size() != 1 || words[0] !== 32'h0458_0000) begin
      failures++;
      $display("FAIL dc_eob_word: count=%0d first=%h required 1 word 04580000",
               words.size(), (words.size() > 0) ? words[0] : 32'hx);
    end
    checks++;
    if (bit_cnt !== 32'd14) begin
      failures++;
      $display("FAIL dc_eob_bit_cnt: got %0d required 14", bit_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (flush_done !== 1'b0) begin
      failures++;
      $display("FAIL flush_done_width: got %0b required 0", flush_done);
    end
  endtask

  task automatic test_ac();
    do_reset();
    send_token(1'b0, 1'b0, 6'd3, 16'hFFFB);
    run_flush();
    checks++;
    if (words.size() != 1 || words[0] !== 32'h043F_FB00) begin
      failures++;
      $display("FAIL ac_word: count=%0d first=%h required 1 word 043ffb00",
               words.size(), (words.size() > 0) ? words[0] : 32'hx);
    end
    checks++;
    if (bit_cnt !== 32'd24) begin
      failures++;
      $display("FAIL ac_bit_cnt: got %0d required 24", bit_cnt);
    end
  endtask

  task automatic test_clip();
    logic [15:0] vin [3];
    logic [31:0] exp_w [3];
    vin[0] = 16'h7FFF; exp_w[0] = 32'h0407_FF00;
    vin[1] = 16'h8000; exp_w[1] = 32'h0408_0100;
    vin[2] = 16'hF801; exp_w[2] = 32'h0408_0100;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      send_token(1'b0, 1'b0, 6'd0, vin[k]);
      run_flush();
      checks++;
      if (words.size() != 1 || words[0] !== exp_w[k]) begin
        failures++;
        $display("FAIL clip_%0d: val=%h word=%h required %h", k, vin[k],
                 (words.size() > 0) ? words[0] : 32'hx, exp_w[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    do_reset();
    o_ready = 1'b0;
    send_token(1'b0, 1'b0, 6'd0, 16'h0001);
    send_token(1'b0, 1'b0, 6'd1, 16'h0002);
    held = o_data;
    checks++;
    if (held !== 32'h0400_0104) begin
      failures++;
      $display("FAIL bp_word: got %h required 04000104", held);
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rdy !== 1'b0 || o_valid !== 1'b1 || o_data !== 32'h0400_0104) begin
        failures++;
        $display("FAIL bp_hold_%0d: rdy=%0b o_valid=%0b o_data=%h required 0 1 04000104",
                 c, rdy, o_valid, o_data);
      end
      @(posedge clk); #1;
    end
    o_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rdy !== 1'b1 || o_valid !== 1'b0 || bit_cnt !== 32'd48) begin
      failures++;
      $display("FAIL bp_release: rdy=%0b o_valid=%0b bit_cnt=%0d required 1 0 48",
               rdy, o_valid, bit_cnt);
    end
    run_flush();
    checks++;
    if (words.size() != 1 || words[0] !== 32'h1002_0000) begin
      failures++;
      $display("FAIL bp_tail: count=%0d first=%h required 1 word 10020000",
               words.size(), (words.size() > 0) ? words[0] : 32'hx);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    send_token(1'b1, 1'b0, 6'd0, 16'h0ABC);
    send_token(1'b0, 1'b0, 6'd5, 16'h0000);
    checks++;
    if (err !== 1'b1 || rdy !== 1'b1 || bit_cnt !== 32'd12) begin
      failures++;
      $display("FAIL illegal_pulse: err=%0b rdy=%0b bit_cnt=%0d required 1 1 12",
               err, rdy, bit_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL illegal_width: err=%0b required 0", err);
    end
    run_flush();
    checks++;
    if (words.size() != 1 || words[0] !== 32'hABC0_0000) begin
      failures++;
      $display("FAIL illegal_word: count=%0d first=%h required 1 word abc00000",
               words.size(), (words.size() > 0) ? words[0] : 32'hx);
    end
  endtask

  task automatic test_flush_empty();
    do_reset();
    run_flush();
    checks++;
    if (words.size() != 0) begin
      failures++;
      $display("FAIL flush_empty_words: count=%0d required 0", words.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    flush = 1'b1;
    send_token(1'b1, 1'b1, 6'd0, 16'h0045);
    run_flush();
    checks++;
    if (words.size() != 1 || words[0] !== 32'h0458_0000) begin
      failures++;
      $display("FAIL en_flush_word: count=%0d first=%h required 1 word 04580000",
               words.size(), (words.size() > 0) ? words[0] : 32'hx);
    end
  endtask

  task automatic test_reset_in_flush();
    bit bad;
    do_reset();
    send_token(1'b1, 1'b1, 6'd0, 16'h0123);
    send_token(1'b0, 1'b1, 6'd0, 16'h0000);
    send_token(1'b0, 1'b1, 6'd0, 16'h0000);
    send_token(1'b0, 1'b1, 6'd0, 16'h0000);
    flush = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    flush = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (rdy !== 1'b1 || o_valid !== 1'b0 || flush_done !== 1'b0 || bit_cnt !== 32'd0) begin
      failures++;
      $display("FAIL rst_flush_state: rdy=%0b o_valid=%0b flush_done=%0b bit_cnt=%0d required 1 0 0 0",
               rdy, o_valid, flush_done, bit_cnt);
    end
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (o_valid || flush_done) bad = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL rst_flush_quiet: spurious o_valid or flush_done seen, required none");
    end
    send_token(1'b1, 1'b1, 6'd0, 16'h0045);
    run_flush();
    checks++;
    if (words.size() != 1 || words[0] !== 32'h0458_0000) begin
      failures++;
      $display("FAIL rst_flush_fresh: count=%0d first=%h required 1 word 04580000",
               words.size(), (words.size() > 0) ? words[0] : 32'hx);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_dc_eob();
    test_ac();
    test_clip();
    test_backpressure();
    test_illegal();
    test_flush_empty();
    test_back_to_back();
    test_reset_in_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
